// File: rtl/crypt_pipe.sv
// crypt_pipe: fully pipelined N-bit encrypt/decrypt datapath, one cipher round
// per stage. Every beat carries its own mode bit and key snapshot, so modes can
// interleave freely and the key may change while beats are in flight.
module crypt_pipe #(
  parameter int N      = 8,
  parameter int ROUNDS = 4
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         en,
  input  logic         mode,
  input  logic         key_ld,
  input  logic [N-1:0] key,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic         v,
  output logic [15:0]  cnt
);

  // The last stage never forwards its mode/key, so only ROUNDS-1 snapshots are kept.
  localparam int SR = (ROUNDS > 1) ? ROUNDS - 1 : 1;

  // Rotate left by s mod N; s is always a per-stage constant here.
  function automatic logic [N-1:0] rotl(input logic [N-1:0] x, input int s);
    int sm;
    sm = s % N;
    if (sm == 0) return x;
    return (x << sm) | (x >> (N - sm));
  endfunction

  // Encrypt round: rotl(x ^ k, 1) + r.
  function automatic logic [N-1:0] enc_round(input logic [N-1:0] x,
                                             input logic [N-1:0] k,
                                             input logic [N-1:0] rc);
    logic [N-1:0] t;
    t = x ^ k;
    t = {t[N-2:0], t[N-1]};
    return t + rc;
  endfunction

  // Decrypt round: rotr(x - r, 1) ^ k, the exact inverse of enc_round.
  function automatic logic [N-1:0] dec_round(input logic [N-1:0] x,
                                             input logic [N-1:0] k,
                                             input logic [N-1:0] rc);
    logic [N-1:0] t;
    t = x - rc;
    t = {t[0], t[N-1:1]};
    return t ^ k;
  endfunction

  logic [N-1:0]              key_reg;
  logic [N-1:0]              key_eff;
  logic [ROUNDS-1:0]         valid_reg;
  logic [ROUNDS-1:0][N-1:0]  data_reg;
  logic [SR-1:0]             mode_reg;
  logic [SR-1:0][N-1:0]      skey_reg;
  logic [15:0]               cnt_reg;

  // Per-stage inputs and the combinational result of that stage's round.
  logic [ROUNDS-1:0]         in_valid;
  logic [ROUNDS-1:0]         in_mode;
  logic [ROUNDS-1:0][N-1:0]  in_data;
  logic [ROUNDS-1:0][N-1:0]  in_key;
  logic [ROUNDS-1:0][N-1:0]  round_out;

  // A beat arriving alongside key_ld already uses the new key.
  assign key_eff = key_ld ? key : key_reg;

  genvar gi;
  generate
    for (gi = 0; gi < ROUNDS; gi++) begin : g_stage
      localparam logic [N-1:0] ENC_RC = N'(gi);
      localparam logic [N-1:0] DEC_RC = N'(ROUNDS - 1 - gi);

      if (gi == 0) begin : g_head
        assign in_valid[gi] = en;
        assign in_mode[gi]  = mode;
        assign in_data[gi]  = din;
        assign in_key[gi]   = key_eff;
      end else begin : g_body
        assign in_valid[gi] = valid_reg[gi-1];
        assign in_mode[gi]  = mode_reg[gi-1];
        assign in_data[gi]  = data_reg[gi-1];
        assign in_key[gi]   = skey_reg[gi-1];
      end

      // Encrypt walks rounds 0..ROUNDS-1 forward, decrypt walks them backward.
      assign round_out[gi] = in_mode[gi]
                           ? enc_round(in_data[gi], rotl(in_key[gi], gi), ENC_RC)
                           : dec_round(in_data[gi], rotl(in_key[gi], ROUNDS - 1 - gi), DEC_RC);
    end
  endgenerate

  // Key register: loads on key_ld, cleared by reset.
  always_ff @(posedge clock) begin
    if (!rst) begin
      key_reg <= '0;
    end else if (key_ld) begin
      key_reg <= key;
    end
  end

  // Pipeline shift plus result counter; the last stage holds data on bubbles.
  always_ff @(posedge clock) begin
    if (!rst) begin
      valid_reg <= '0;
      data_reg  <= '0;
      mode_reg  <= '0;
      skey_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      valid_reg <= in_valid;
      for (int i = 0; i < ROUNDS; i++) begin
        if (i != ROUNDS - 1 || in_valid[i]) data_reg[i] <= round_out[i];
      end
      for (int i = 0; i < ROUNDS - 1; i++) begin
        mode_reg[i] <= in_mode[i];
        skey_reg[i] <= in_key[i];
      end
      if (in_valid[ROUNDS-1]) cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign v    = valid_reg[ROUNDS-1];
  assign dout = data_reg[ROUNDS-1];
  assign cnt  = cnt_reg;

endmodule

// File: tb/tb_crypt_pipe.sv
// Testbench for crypt_pipe: directed vectors plus randomized streams checked
// against a whole-cipher reference model.
module tb_crypt_pipe;
  localparam int N      = 8;
  localparam int ROUNDS = 4;

  logic         clock = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         mode = 1'b0;
  logic         key_ld = 1'b0;
  logic [N-1:0] key = '0;
  logic [N-1:0] din = '0;
  logic [N-1:0] dout;
  logic         v;
  logic [15:0]  cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [N-1:0] model_key = '0;

  logic [N-1:0] got_data[$];
  logic [15:0]  got_cnt[$];
  int           got_cyc[$];
  logic [N-1:0] exp_data[$];
  logic [N-1:0] exp_din[$];
  logic         exp_mode[$];
  logic [N-1:0] exp_key[$];

  crypt_pipe #(.N(N), .ROUNDS(ROUNDS)) dut (
    .clock (clock),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .key_ld(key_ld),
    .key   (key),
    .din   (din),
    .dout  (dout),
    .v     (v),
    .cnt   (cnt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Collect every result the DUT emits.
  always @(negedge clock) begin
    if (v) begin
      got_data.push_back(dout);
      got_cnt.push_back(cnt);
      got_cyc.push_back(cyc);
    end
  end

  // Reference cipher, straight from the round definitions.
  function automatic logic [N-1:0] m_rotl(input logic [N-1:0] x, input int s);
    int sm;
    sm = s % N;
    if (sm == 0) return x;
    return N'((x << sm) | (x >> (N - sm)));
  endfunction

  function automatic logic [N-1:0] m_enc(input logic [N-1:0] d, input logic [N-1:0] k);
    logic [N-1:0] x;
    x = d;
    for (int r = 0; r < ROUNDS; r++) x = m_rotl(x ^ m_rotl(k, r), 1) + N'(r);
    return x;
  endfunction

  function automatic logic [N-1:0] m_dec(input logic [N-1:0] d, input logic [N-1:0] k);
    logic [N-1:0] x;
    x = d;
    for (int r = ROUNDS - 1; r >= 0; r--) x = m_rotl(x - N'(r), N - 1) ^ m_rotl(k, r);
    return x;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one beat; the caller's next step() samples it.
  task automatic set_beat(input logic m, input logic [N-1:0] d,
                          input logic ld, input logic [N-1:0] k);
    logic [N-1:0] keff;
    en = 1'b1; mode = m; din = d; key_ld = ld; key = k;
    keff = ld ? k : model_key;
    if (rst) begin
      exp_data.push_back(m ? m_enc(d, keff) : m_dec(d, keff));
      exp_din.push_back(d);
      exp_mode.push_back(m);
      exp_key.push_back(keff);
      if (ld) model_key = k;
    end
  endtask

  task automatic set_idle();
    en = 1'b0; key_ld = 1'b0;
  endtask

  task automatic clear_q();
    got_data.delete(); got_cnt.delete(); got_cyc.delete();
    exp_data.delete(); exp_din.delete(); exp_mode.delete(); exp_key.delete();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    set_idle();
    repeat (n) step();
    rst = 1'b1;
    model_key = '0;
    clear_q();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_idle();
    for (int c = 0; c < 6; c++) begin
      if (c == 3) rst = 1'b1;
      step();
      tests_run++;
      if (v !== 1'b0 || dout !== 8'h00 || cnt !== 16'd0) begin
        tests_failed++;
        $display("FAIL reset_idle cycle %0d: got v=%b dout=%h cnt=%h, expected v=0 dout=00 cnt=0000", c, v, dout, cnt);
      end
    end
    $display("[TB] reset/idle checked over 6 cycles");
    clear_q();
  endtask

  // One beat, then verify the result appears exactly ROUNDS cycles later.
  task automatic latency_beat(input string name, input logic m, input logic [N-1:0] d,
                              input logic [N-1:0] want, input logic [15:0] want_cnt);
    set_beat(m, d, 1'b0, '0);
    step();
    set_idle();
    for (int k = 1; k <= ROUNDS + 2; k++) begin
      tests_run++;
      if (v !== (k == ROUNDS)) begin
        tests_failed++;
        $display("FAIL %s_latency k=%0d: got v=%b expected v=%b", name, k, v, (k == ROUNDS));
      end
      if (k == ROUNDS) begin
        tests_run++;
        if (dout !== want || dout !== exp_data[0]) begin
          tests_failed++;
          $display("FAIL %s_data: got %h expected %h (model %h)", name, dout, want, exp_data[0]);
        end
        tests_run++;
        if (cnt !== want_cnt) begin
          tests_failed++;
          $display("FAIL %s_cnt: got %h expected %h", name, cnt, want_cnt);
        end
        $display("[TB] %s din=%h dout=%h cnt=%h", name, d, dout, cnt);
      end
      step();
    end
    clear_q();
  endtask

  task automatic test_basic();
    latency_beat("basic_enc", 1'b1, 8'h0B, 8'hBB, 16'd1);
    latency_beat("basic_dec", 1'b0, 8'hBB, 8'h0B, 16'd2);
  endtask

  // Compare collected outputs with a list of required words and counts.
  task automatic check_burst(input string name, input logic [N-1:0] w0, input logic [N-1:0] w1,
                             input logic [N-1:0] w2, input int nres, input logic [15:0] cnt0);
    logic [N-1:0] want [3];
    want[0] = w0; want[1] = w1; want[2] = w2;
    tests_run++;
    if (got_data.size() !== nres) begin
      tests_failed++;
      $display("FAIL %s_count: got %0d results expected %0d", name, got_data.size(), nres);
    end else begin
      for (int i = 0; i < nres; i++) begin
        tests_run++;
        if (got_data[i] !== want[i] || got_data[i] !== exp_data[i]) begin
          tests_failed++;
          $display("FAIL %s_data[%0d]: got %h expected %h", name, i, got_data[i], want[i]);
        end
        tests_run++;
        if (got_cnt[i] !== cnt0 + 16'(i)) begin
          tests_failed++;
          $display("FAIL %s_cnt[%0d]: got %h expected %h", name, i, got_cnt[i], cnt0 + 16'(i));
        end
        if (i > 0) begin
          tests_run++;
          if (got_cyc[i] - got_cyc[i-1] !== 1) begin
            tests_failed++;
            $display("FAIL %s_b2b[%0d]: got gap %0d expected 1", name, i, got_cyc[i] - got_cyc[i-1]);
          end
        end
        $display("[TB] %s result %0d dout=%h cnt=%h", name, i, got_data[i], got_cnt[i]);
      end
    end
  endtask

  task automatic test_key_load();
    clear_q();
    set_beat(1'b1, 8'h0B, 1'b1, 8'hA5); step();
    set_beat(1'b0, 8'hAB, 1'b0, 8'h00); step();
    set_idle();
    repeat (ROUNDS + 3) step();
    check_burst("key_load", 8'hAB, 8'h0B, 8'h00, 2, 16'd3);
  endtask

  task automatic test_mixed();
    do_reset(1);
    tests_run++;
    if (cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL mixed_cnt_start: got %h expected 0000", cnt);
    end
    set_beat(1'b1, 8'h0B, 1'b0, 8'h00); step();
    set_beat(1'b1, 8'h0B, 1'b1, 8'hA5); step();
    set_beat(1'b0, 8'hAB, 1'b0, 8'h00); step();
    set_idle();
    repeat (ROUNDS + 3) step();
    check_burst("mixed", 8'hBB, 8'hAB, 8'h0B, 3, 16'd1);
    tests_run++;
    if (cnt !== 16'd3) begin
      tests_failed++;
      $display("FAIL mixed_cnt_end: got %h expected 0003", cnt);
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    set_beat(1'b1, 8'h0B, 1'b1, 8'hA5); step();
    set_beat(1'b1, 8'h11, 1'b0, 8'h00); step();
    rst = 1'b0;
    set_beat(1'b0, 8'h22, 1'b0, 8'h00); step();
    rst = 1'b1;
    model_key = '0;
    set_idle();
    repeat (ROUNDS + 4) step();
    tests_run++;
    if (got_data.size() !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_drop: got %0d results expected 0", got_data.size());
    end
    tests_run++;
    if (cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_cnt: got %h expected 0000", cnt);
    end
    $display("[TB] reset_mid dropped=%0d cnt=%h", 3 - got_data.size(), cnt);
    clear_q();
    set_beat(1'b1, 8'h0B, 1'b0, 8'h00); step();
    set_idle();
    repeat (ROUNDS + 3) step();
    check_burst("reset_mid_after", 8'hBB, 8'h00, 8'h00, 1, 16'd1);
  endtask

  // Randomized stream (gaps allowed unless dense); checks data, cnt, spacing and round trip.
  task automatic run_random(input string name, input int nbeats, input bit dense,
                            input bit quiet);
    logic [15:0] c0;
    logic [N-1:0] back;
    int issued;
    c0 = cnt;
    clear_q();
    issued = 0;
    while (issued < nbeats) begin
      if (dense || $urandom_range(0, 3) != 0) begin
        set_beat(1'($urandom_range(0, 1)), N'($urandom), ($urandom_range(0, 7) == 0), N'($urandom));
        issued++;
      end else begin
        set_idle();
        if ($urandom_range(0, 1) == 1) begin
          key_ld = 1'b1; key = N'($urandom); model_key = key;
        end
      end
      step();
    end
    set_idle();
    repeat (ROUNDS + 3) step();
    tests_run++;
    if (got_data.size() !== nbeats) begin
      tests_failed++;
      $display("FAIL %s_count: got %0d results expected %0d", name, got_data.size(), nbeats);
    end else begin
      for (int i = 0; i < nbeats; i++) begin
        tests_run++;
        if (got_data[i] !== exp_data[i]) begin
          tests_failed++;
          $display("FAIL %s_data[%0d]: got %h expected %h", name, i, got_data[i], exp_data[i]);
        end
        back = exp_mode[i] ? m_dec(got_data[i], exp_key[i]) : m_enc(got_data[i], exp_key[i]);
        tests_run++;
        if (back !== exp_din[i]) begin
          tests_failed++;
          $display("FAIL %s_roundtrip[%0d]: got %h expected %h", name, i, back, exp_din[i]);
        end
        tests_run++;
        if (got_cnt[i] !== c0 + 16'(i + 1)) begin
          tests_failed++;
          $display("FAIL %s_cnt[%0d]: got %h expected %h", name, i, got_cnt[i], c0 + 16'(i + 1));
        end
        if (dense && i > 0) begin
          tests_run++;
          if (got_cyc[i] - got_cyc[i-1] !== 1) begin
            tests_failed++;
            $display("FAIL %s_b2b[%0d]: got gap %0d expected 1", name, i, got_cyc[i] - got_cyc[i-1]);
          end
        end
        if (!quiet || (i % 4096) == 0)
          $display("[TB] %s beat %0d mode=%b din=%h dout=%h cnt=%h", name, i, exp_mode[i], exp_din[i], got_data[i], got_cnt[i]);
      end
    end
  endtask

  task automatic test_random();
    run_random("random", 200, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back_wrap();
    do_reset(1);
    run_random("wrap", 65537, 1'b1, 1'b1);
    if (got_cnt.size() == 65537) begin
      tests_run++;
      if (got_cnt[65534] !== 16'hFFFF || got_cnt[65535] !== 16'h0000 || got_cnt[65536] !== 16'h0001) begin
        tests_failed++;
        $display("FAIL wrap_edge: got %h,%h,%h expected ffff,0000,0001", got_cnt[65534], got_cnt[65535], got_cnt[65536]);
      end
      $display("[TB] wrap cnt sequence %h -> %h -> %h", got_cnt[65534], got_cnt[65535], got_cnt[65536]);
    end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_key_load();
    test_mixed();
    test_reset_mid();
    test_random();
    test_back_to_back_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
